// File: rtl/matrix_scheduler_pkg.sv
// matrix_pkg: shared types and constants for the 5x7 LED matrix scheduler.
// Contents:
//   mstate_t  - scheduler state (IDLE, SHOW_REGA, SHOW_CAIXA, BLANK)
//   N_COLS    - number of column drivers (5)
//   N_ROWS    - number of rows per column (7)
//   COLS_OFF  - column drive pattern with every column switched off
//   col_mask  - active-low one-hot column drive for a column index
// BLANK is only reachable when MATRIX_BLANK_EN is defined.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHOW_REGA  = 2'd1,
    SHOW_CAIXA = 2'd2,
    BLANK      = 2'd3
  } mstate_t;

  localparam int N_COLS = 5;
  localparam int N_ROWS = 7;
  localparam logic [N_COLS-1:0] COLS_OFF = 5'b11111;

  // Columns are driven low, so the selected column is the single zero bit.
  function automatic logic [N_COLS-1:0] col_mask(input logic [2:0] idx);
    return ~(5'b00001 << idx);
  endfunction

endpackage

// File: rtl/matrix_scheduler_if.sv
// matrix_scheduler_if: bundle between the system controller and the matrix
// scheduler.
// Signals:
//   en          - display enable (controller -> scheduler)
//   alert_rega  - irrigation alert (controller -> scheduler)
//   alert_caixa - tank alert (controller -> scheduler)
//   sel         - row mux select, 1 = rega rows, 0 = caixa rows
//   col         - active-low one-hot column drive
//   col_idx     - current column index 0..4
//   frame_done  - one-cycle pulse at the start of each new frame
//   blank       - high whenever all columns are off
// Modports: master (controller side), slave (scheduler side).
interface matrix_scheduler_if;
  import matrix_pkg::*;

  logic              en;
  logic              alert_rega;
  logic              alert_caixa;
  logic              sel;
  logic [N_COLS-1:0] col;
  logic [2:0]        col_idx;
  logic              frame_done;
  logic              blank;

  modport master (
    output en, alert_rega, alert_caixa,
    input  sel, col, col_idx, frame_done, blank
  );

  modport slave (
    input  en, alert_rega, alert_caixa,
    output sel, col, col_idx, frame_done, blank
  );

endinterface

// File: rtl/matrix_scheduler_scan_ticker.sv
// scan_ticker: column-period prescaler for the matrix scheduler.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   clr     - synchronous clear, holds the count at zero while high
//   tick    - high during the cycle in which the count wraps
// Parameter SCAN_DIV (>=2) is the number of cycles per column period.
module scan_ticker #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_cnt;

  // Counts 0..SCAN_DIV-1 and restarts; a clear parks the count at zero so
  // the first column after enable lasts a full period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = !clr && (r_cnt == LAST);

endmodule

// File: rtl/matrix_scheduler.sv
// matrix_scheduler: shares the 5x7 LED matrix between the rega and caixa row
// sources, scanning the five active-low columns and switching the row mux
// only at frame boundaries (dwell rotation with alert priority).
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   bus     - matrix_scheduler_if.slave (en, alerts in; sel, col, col_idx,
//             frame_done, blank out; all outputs registered)
// Parameters: SCAN_DIV (cycles per column, >=2), DWELL_FRAMES (frames per
// source before rotating, >=1).
// Option: define MATRIX_BLANK_EN to insert one fully blanked frame on every
// source switch.
module matrix_scheduler
  import matrix_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DWELL_FRAMES = 50
) (
  input logic                clk,
  input logic                reset_n,
  matrix_scheduler_if.slave  bus
);

  localparam int DW = $clog2(DWELL_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_FRAMES);

  mstate_t           r_state;
  logic              r_sel;
  logic [N_COLS-1:0] r_col;
  logic [2:0]        r_col_idx;
  logic              r_frame_done;
  logic              r_blank;
  logic [DW-1:0]     r_dwell;

  logic          w_clr;
  logic          w_tick;
  logic          w_wrap;
  logic [2:0]    w_idx_next;
  logic [DW-1:0] w_dwell_inc;
  logic [DW-1:0] w_dwell_after;
  logic          w_alert_cur;
  logic          w_alert_oth;
  logic          w_switch;

  assign w_clr = (r_state == IDLE) || !bus.en;

  scan_ticker #(.SCAN_DIV(SCAN_DIV)) u_ticker (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_clr),
    .tick    (w_tick)
  );

  assign w_idx_next  = (r_col_idx == 3'd4) ? 3'd0 : r_col_idx + 3'd1;
  assign w_wrap      = w_tick && (r_col_idx == 3'd4);
  assign w_dwell_inc = (r_dwell == DWELL_MAX) ? r_dwell : r_dwell + 1'b1;

  // Frame-boundary decision. A lone alert wins outright (switch toward it or
  // lock onto it); matching alerts fall back to plain dwell rotation.
  always_comb begin
    w_alert_cur = (r_state == SHOW_CAIXA) ? bus.alert_caixa : bus.alert_rega;
    w_alert_oth = (r_state == SHOW_CAIXA) ? bus.alert_rega  : bus.alert_caixa;
    w_switch    = 1'b0;
    w_dwell_after = w_dwell_inc;
    if (w_alert_oth != w_alert_cur) begin
      w_switch      = w_alert_oth;
      w_dwell_after = '0;
    end else if (w_dwell_inc >= DWELL_MAX) begin
      w_switch      = 1'b1;
      w_dwell_after = '0;
    end
  end

  // Scheduler FSM with registered outputs. sel changes on the same edge that
  // returns col_idx to 0 so rows and columns never disagree.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_sel        <= 1'b1;
      r_col        <= COLS_OFF;
      r_col_idx    <= 3'd0;
      r_frame_done <= 1'b0;
      r_blank      <= 1'b1;
      r_dwell      <= '0;
    end else if (!bus.en) begin
      r_state      <= IDLE;
      r_col        <= COLS_OFF;
      r_col_idx    <= 3'd0;
      r_frame_done <= 1'b0;
      r_blank      <= 1'b1;
      r_dwell      <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state   <= SHOW_REGA;
          r_sel     <= 1'b1;
          r_col     <= col_mask(3'd0);
          r_col_idx <= 3'd0;
          r_blank   <= 1'b0;
          r_dwell   <= '0;
        end
        SHOW_REGA, SHOW_CAIXA: begin
          if (w_tick) begin
            r_col_idx <= w_idx_next;
            r_col     <= col_mask(w_idx_next);
            if (w_wrap) begin
              r_frame_done <= 1'b1;
              r_dwell      <= w_dwell_after;
              if (w_switch) begin
                r_sel <= (r_state == SHOW_CAIXA);
`ifdef MATRIX_BLANK_EN
                r_state <= BLANK;
                r_col   <= COLS_OFF;
                r_blank <= 1'b1;
`else
                r_state <= (r_state == SHOW_REGA) ? SHOW_CAIXA : SHOW_REGA;
`endif
              end
            end
          end
        end
`ifdef MATRIX_BLANK_EN
        // sel already points at the new source; this frame is not dwelled
        // and its end is not a decision point.
        BLANK: begin
          if (w_tick) begin
            r_col_idx <= w_idx_next;
            if (w_wrap) begin
              r_frame_done <= 1'b1;
              r_state      <= r_sel ? SHOW_REGA : SHOW_CAIXA;
              r_col        <= col_mask(3'd0);
              r_blank      <= 1'b0;
            end
          end
        end
`endif
        default: begin
          r_state <= IDLE;
          r_col   <= COLS_OFF;
          r_blank <= 1'b1;
        end
      endcase
    end
  end

  assign bus.sel        = r_sel;
  assign bus.col        = r_col;
  assign bus.col_idx    = r_col_idx;
  assign bus.frame_done = r_frame_done;
  assign bus.blank      = r_blank;

endmodule

// File: tb/tb_matrix_scheduler.sv
// tb_matrix_scheduler: self-checking bench for matrix_scheduler with
// SCAN_DIV=4 and DWELL_FRAMES=2. A time-based reference model predicts every
// output each cycle; directed scenarios pin key values with literals, then a
// randomized phase exercises enable drops and alert changes.
// Honours MATRIX_BLANK_EN the same way as the design.
module tb_matrix_scheduler;
  import matrix_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DWELL    = 2;
  localparam int FRAME    = 5 * SCAN_DIV;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int checks = 0;
  int errors = 0;

  matrix_scheduler_if bus();

  matrix_scheduler #(
    .SCAN_DIV     (SCAN_DIV),
    .DWELL_FRAMES (DWELL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: mT counts cycles since the current display run
  // started, so column and frame positions follow from plain division.
  bit   mOn    = 1'b0;
  int   mT     = 0;
  bit   mSel   = 1'b1;
  int   mDwell = 0;
  bit   mBlank = 1'b0;
  bit   mFd    = 1'b0;
  logic [4:0] expCol   = 5'b11111;
  int         expIdx   = 0;
  bit         expBlank = 1'b1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit ar, input bit ac);
    bus.en          = en;
    bus.alert_rega  = ar;
    bus.alert_caixa = ac;
  endtask

  // Model update on every active edge or reset assertion.
  initial begin
    bit ar, ac, aCur, aOth, doSwitch;
    forever begin
      @(posedge clk or negedge reset_n);
      mFd = 1'b0;
      if (!reset_n) begin
        mOn = 1'b0; mT = 0; mSel = 1'b1; mDwell = 0; mBlank = 1'b0;
      end else if (!bus.en) begin
        mOn = 1'b0; mT = 0; mDwell = 0; mBlank = 1'b0;
      end else if (!mOn) begin
        mOn = 1'b1; mT = 0; mSel = 1'b1; mDwell = 0; mBlank = 1'b0;
      end else begin
        mT++;
        if (mT % FRAME == 0) begin
          mFd = 1'b1;
          if (mBlank) begin
            mBlank = 1'b0;
          end else begin
            ar = bus.alert_rega;
            ac = bus.alert_caixa;
            aCur = mSel ? ar : ac;
            aOth = mSel ? ac : ar;
            mDwell++;
            doSwitch = 1'b0;
            if (aOth && !aCur) begin
              doSwitch = 1'b1;
              mDwell = 0;
            end else if (aCur && !aOth) begin
              mDwell = 0;
            end else if (mDwell >= DWELL) begin
              doSwitch = 1'b1;
              mDwell = 0;
            end
            if (doSwitch) begin
              mSel = !mSel;
`ifdef MATRIX_BLANK_EN
              mBlank = 1'b1;
`endif
            end
          end
        end
      end
      expIdx   = mOn ? (mT / SCAN_DIV) % 5 : 0;
      expCol   = (mOn && !mBlank) ? ~(5'b00001 << expIdx) : 5'b11111;
      expBlank = !(mOn && !mBlank);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model.col", int'(bus.col), int'(expCol));
      checkOutput("model.col_idx", int'(bus.col_idx), expIdx);
      checkOutput("model.sel", int'(bus.sel), int'(mSel));
      checkOutput("model.frame_done", int'(bus.frame_done), int'(mFd));
      checkOutput("model.blank", int'(bus.blank), int'(expBlank));
    end
  end

  initial begin
    int offLeft;
    bit en, ar, ac;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset.col", int'(bus.col), 'h1f);
    checkOutput("reset.blank", int'(bus.blank), 1);
    checkOutput("reset.sel", int'(bus.sel), 1);
    checkOutput("reset.col_idx", int'(bus.col_idx), 0);
    checkOutput("reset.frame_done", int'(bus.frame_done), 0);
    reset_n = 1'b1;

    // Plain rotation, no alerts.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rot.c0.col", int'(bus.col), 'h1e);
    checkOutput("rot.c0.blank", int'(bus.blank), 0);
    checkOutput("rot.c0.sel", int'(bus.sel), 1);
    repeat (4) @(negedge clk);
    checkOutput("rot.c4.col", int'(bus.col), 'h1d);
    checkOutput("rot.c4.col_idx", int'(bus.col_idx), 1);
    repeat (16) @(negedge clk);
    checkOutput("rot.c20.frame_done", int'(bus.frame_done), 1);
    checkOutput("rot.c20.col_idx", int'(bus.col_idx), 0);
    checkOutput("rot.c20.model_fd", int'(mFd), 1);
    checkOutput("rot.c20.sel", int'(bus.sel), 1);
    @(negedge clk);
    checkOutput("rot.c21.frame_done", int'(bus.frame_done), 0);
    repeat (18) @(negedge clk);
    checkOutput("rot.c39.sel", int'(bus.sel), 1);
    @(negedge clk);
    checkOutput("rot.c40.sel", int'(bus.sel), 0);
    checkOutput("rot.c40.model_sel", int'(mSel), 0);
`ifdef MATRIX_BLANK_EN
    checkOutput("rot.c40.col", int'(bus.col), 'h1f);
    checkOutput("rot.c40.blank", int'(bus.blank), 1);
    repeat (20) @(negedge clk);
    checkOutput("rot.c60.col", int'(bus.col), 'h1e);
    checkOutput("rot.c60.sel", int'(bus.sel), 0);
    checkOutput("rot.c60.blank", int'(bus.blank), 0);
`else
    checkOutput("rot.c40.col", int'(bus.col), 'h1e);
    checkOutput("rot.c40.blank", int'(bus.blank), 0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("off.col", int'(bus.col), 'h1f);
    checkOutput("off.blank", int'(bus.blank), 1);
    checkOutput("off.sel_kept", int'(bus.sel), 0);

    // Caixa alert lock.
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    checkOutput("lock.c20.sel", int'(bus.sel), 0);
    repeat (80) @(negedge clk);
    checkOutput("lock.c100.sel", int'(bus.sel), 0);

    // Enable dropped mid-frame, then restart.
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    repeat (26) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drop.col", int'(bus.col), 'h1f);
    checkOutput("drop.blank", int'(bus.blank), 1);
    checkOutput("drop.frame_done", int'(bus.frame_done), 0);
    checkOutput("drop.col_idx", int'(bus.col_idx), 0);
    checkOutput("drop.sel", int'(bus.sel), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("restart.col", int'(bus.col), 'h1e);
    checkOutput("restart.col_idx", int'(bus.col_idx), 0);
    checkOutput("restart.sel", int'(bus.sel), 1);

    // Asynchronous reset between clock edges while caixa is selected.
    repeat (50) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("areset.col", int'(bus.col), 'h1f);
    checkOutput("areset.blank", int'(bus.blank), 1);
    checkOutput("areset.sel", int'(bus.sel), 1);
    checkOutput("areset.col_idx", int'(bus.col_idx), 0);
    checkOutput("areset.frame_done", int'(bus.frame_done), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized enable drops and alert changes.
    offLeft = 0;
    ar = 1'b0;
    ac = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (offLeft > 0) begin
        offLeft--;
        en = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        offLeft = int'($urandom_range(1, 30));
        en = 1'b0;
      end else begin
        en = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) begin
        ar = ($urandom_range(0, 1) != 0);
        ac = ($urandom_range(0, 1) != 0);
      end else if ($urandom_range(0, 39) == 0) begin
        ar = !ar;
      end
      applyStimulus(en, ar, ac);
    end

    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_scheduler.md
# matrix_scheduler

Display scheduler for the 5×7 LED matrix. It shares the matrix between the irrigation (rega) and tank-level (caixa) row sources. It drives the `sel` input of the row multiplexer and, at the same time, scans the five active-low columns. Source switching happens only at frame boundaries, using dwell-time rotation with alert-driven priority. The block sits between the system controller (`en`, alerts) and the matrix pins (row mux select, column drivers).

## Interface
- `SCAN_DIV`, 1000: clock cycles per column period (≥2)
- `DWELL_FRAMES`, 50: full frames shown per source before rotating (≥1)
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `en`  in  1  display enable; low blanks the matrix and clears all counters
- `alert_rega`  in  1  irrigation alert; requests priority for the rega source
- `alert_caixa`  in  1  tank alert; requests priority for the caixa source
- `sel`  out  1  row mux select: 1 = rega rows, 0 = caixa rows
- `col`  out  5  column drive, one-hot active-low; `5'b11111` = all off
- `col_idx`  out  3  current column index, 0..4
- `frame_done`  out  1  one-cycle pulse when a frame completes
- `blank`  out  1  high whenever all columns are off

## Operation
- States:
  - `IDLE`: columns off.
  - `SHOW_REGA`: `sel`=1.
  - `SHOW_CAIXA`: `sel`=0.
  - `BLANK`: only when `MATRIX_BLANK_EN` is defined.
- Reset values: state `IDLE`, `sel`=1, `col`=`5'b11111`, `col_idx`=0, `frame_done`=0, `blank`=1, prescaler=0, dwell counter=0.
- `IDLE`→`SHOW_REGA` when `en`=1. Any state→`IDLE` when `en`=0, including mid-frame; all counters clear.
- Prescaler counts 0..SCAN_DIV-1. Tick = the cycle in which it wraps.
- On each tick, `col_idx` advances 0→1→2→3→4→0.
- `col` = ~(1<<`col_idx`) in SHOW states; `5'b11111` in `IDLE` and `BLANK`.
- A frame is 5 ticks. At the 4→0 wrap, `frame_done`=1 and the dwell counter increments.
- Boundary decision, evaluated at each 4→0 wrap in a SHOW state:
  - Alert for the other source only: switch now and clear dwell.
  - Alert for the current source only: stay and clear dwell (lock).
  - Both alerts or none: switch when dwell reaches DWELL_FRAMES, then clear dwell; otherwise stay.
- Alerts are sampled only at frame boundaries. Alert pulses between boundaries are ignored.
- A switch updates `sel` on the same edge as `col_idx`→0, so rows and columns stay coherent.
- Widths:
  - Prescaler: $clog2(SCAN_DIV) bits.
  - Dwell: $clog2(DWELL_FRAMES+1) bits, saturating, with no wrap.

## Timing
- All outputs are registered. None are combinational from inputs.
- `en` rising: next edge enters `SHOW_REGA` with `col`=`5'b11110` and `blank`=0. The first tick comes SCAN_DIV cycles later.
- `en` falling: next edge gives `col`=`5'b11111` and `blank`=1. `sel` keeps its last value.
- Column period is exactly SCAN_DIV cycles; frame period is exactly 5·SCAN_DIV cycles.
- `frame_done` is high for one cycle, coincident with `col_idx`=0 of the new frame. It is never asserted in `IDLE`.
- DWELL_FRAMES=1: the block alternates every frame when no alerts are active.

## Configuration
- `MATRIX_BLANK_EN` defined:
  - Every source switch passes through `BLANK` for one full frame (5 ticks).
  - During `BLANK`: `sel` already shows the new source, `col`=`5'b11111`, `blank`=1, `col_idx` keeps counting.
  - `frame_done` still pulses at the end of `BLANK`, but the dwell counter does not count that frame.
  - Alerts are not evaluated at the end of `BLANK`.
- Undefined: switching is immediate at the boundary and the `BLANK` state is absent. This suppresses ghosting only where the row mux settles within one cycle.

## Structure
- Package `matrix_pkg`:
  - State enum `mstate_t` (`IDLE`, `SHOW_REGA`, `SHOW_CAIXA`, `BLANK`).
  - Constants `N_COLS`=5, `N_ROWS`=7, `COLS_OFF`=`5'b11111`.
- Sub-module `scan_ticker`: prescaler with parameter SCAN_DIV, inputs `clk`, `reset_n`, `clr`; output `tick`.

## Test plan
- SCAN_DIV=4, DWELL_FRAMES=2, no alerts, `en`=1 → `col` sequence 11110, 11101, 11011, 10111, 01111, each held 4 cycles. `frame_done` every 20 cycles. `sel` toggles 1→0 at cycle 40 after enable.
- `alert_caixa`=1 held from cycle 5 → `sel`=0 at the first boundary (cycle 20) and held indefinitely. Dwell never forces return.
- Both alerts held → same rotation as the no-alert case, toggling every 40 cycles.
- `en` dropped at cycle 27 (mid-column 1, second frame) → next edge gives `col`=`5'b11111`, `blank`=1, no `frame_done`. Re-enable restarts at `SHOW_REGA`, `col_idx`=0.
- `reset_n` asserted asynchronously mid-frame → all outputs take reset values immediately, with no clock edge required.
- `MATRIX_BLANK_EN` defined, same stimulus as scenario 1 → cycles 40–59 give `col`=`5'b11111`, `sel`=0, `blank`=1. Caixa columns start at cycle 60, and the next switch is at cycle 100.
